// File: rtl/instruction_fetcher.sv
// Fetch stage ahead of the instruction queue: one outstanding icache request,
// JAL/BHT-based next-PC prediction, and ROB-driven redirect on roll_back.
module instruction_fetcher #(
    parameter int          BHT_INDEX_WIDTH = 6,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        isq_full,
    input  logic        roll_back,
    input  logic [31:0] rollback_pc,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_valid,
    input  logic [31:0] icache_data,
    output logic        instruction_ready,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        pred_taken_out,
    input  logic        bht_update,
    input  logic [31:0] bht_update_pc,
    input  logic        bht_update_taken
);

    localparam int BHT_SIZE = 1 << BHT_INDEX_WIDTH;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } fetch_state_t;

    fetch_state_t state, state_next;

    logic [31:0] pc, pc_next;
    logic        discard, discard_next;

    logic        req_next;
    logic [31:0] addr_next;
    logic        ready_next;
    logic [31:0] instr_next;
    logic [31:0] pc_out_next;
    logic        pred_next;

    logic [1:0]  bht [BHT_SIZE];

    logic [BHT_INDEX_WIDTH-1:0] pred_idx;
    logic [BHT_INDEX_WIDTH-1:0] upd_idx;
    logic [1:0]  pred_ctr;
    logic [1:0]  upd_ctr;

    logic [6:0]  opcode;
    logic [31:0] jal_imm;
    logic [31:0] br_imm;
    logic [31:0] predicted_pc;
    logic        predicted_taken;

    // Only the index bits of the committed branch PC select a counter.
    logic        unused_upd_pc_bits;
    assign unused_upd_pc_bits = ^{bht_update_pc[31:BHT_INDEX_WIDTH+2], bht_update_pc[1:0]};

    assign pred_idx = pc[BHT_INDEX_WIDTH+1:2];
    assign upd_idx  = bht_update_pc[BHT_INDEX_WIDTH+1:2];
    assign pred_ctr = bht[pred_idx];
    assign upd_ctr  = bht[upd_idx];

    assign opcode  = icache_data[6:0];
    assign jal_imm = {{12{icache_data[31]}}, icache_data[19:12], icache_data[20],
                      icache_data[30:21], 1'b0};
    assign br_imm  = {{20{icache_data[31]}}, icache_data[7], icache_data[30:25],
                      icache_data[11:8], 1'b0};

    always_comb begin
        predicted_pc    = pc + 32'd4;
        predicted_taken = 1'b0;
        if (opcode == OPCODE_JAL) begin
            predicted_pc    = pc + jal_imm;
            predicted_taken = 1'b1;
        end else if (opcode == OPCODE_BRANCH && pred_ctr[1]) begin
            predicted_pc    = pc + br_imm;
            predicted_taken = 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        discard_next = discard;
        req_next     = 1'b0;
        addr_next    = icache_addr;
        ready_next   = 1'b0;
        instr_next   = instruction_out;
        pc_out_next  = pc_out;
        pred_next    = pred_taken_out;

        if (roll_back) begin
            // A word still in flight must be swallowed when it finally returns.
            pc_next = rollback_pc;
            if (state == S_WAIT && !icache_valid) begin
                discard_next = 1'b1;
                state_next   = S_WAIT;
            end else begin
                discard_next = 1'b0;
                state_next   = S_IDLE;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (!isq_full) begin
                        req_next   = 1'b1;
                        addr_next  = pc;
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (icache_valid) begin
                        state_next = S_IDLE;
                        if (discard) begin
                            discard_next = 1'b0;
                        end else begin
                            ready_next  = 1'b1;
                            instr_next  = icache_data;
                            pc_out_next = pc;
                            pred_next   = predicted_taken;
                            pc_next     = predicted_pc;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state             <= S_IDLE;
            pc                <= RESET_PC;
            discard           <= 1'b0;
            icache_req        <= 1'b0;
            icache_addr       <= RESET_PC;
            instruction_ready <= 1'b0;
            instruction_out   <= 32'h0;
            pc_out            <= 32'h0;
            pred_taken_out    <= 1'b0;
        end else if (rdy_in) begin
            state             <= state_next;
            pc                <= pc_next;
            discard           <= discard_next;
            icache_req        <= req_next;
            icache_addr       <= addr_next;
            instruction_ready <= ready_next;
            instruction_out   <= instr_next;
            pc_out            <= pc_out_next;
            pred_taken_out    <= pred_next;
        end
    end

    // Counters start weakly not-taken and saturate at both ends.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int k = 0; k < BHT_SIZE; k++) begin
                bht[k] <= 2'b01;
            end
        end else if (rdy_in && bht_update) begin
            if (bht_update_taken) begin
                if (upd_ctr != 2'b11) begin
                    bht[upd_idx] <= upd_ctr + 2'b01;
                end
            end else begin
                if (upd_ctr != 2'b00) begin
                    bht[upd_idx] <= upd_ctr - 2'b01;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Scoreboard bench for instruction_fetcher: an icache model answers requests,
// expected pushes are queued on response and compared when the DUT pushes.
module tb_instruction_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        isq_full;
    logic        roll_back;
    logic [31:0] rollback_pc;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_valid;
    logic [31:0] icache_data;
    logic        instruction_ready;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        pred_taken_out;
    logic        bht_update;
    logic [31:0] bht_update_pc;
    logic        bht_update_taken;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] JAL1 = 32'h0100_006F;
    localparam logic [31:0] JAL2 = 32'h0200_006F;
    localparam logic [31:0] BEQ  = 32'h0000_0463;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } push_t;

    push_t exp_q[$];
    push_t mon_e;
    push_t new_e;
    int    checks = 0;
    int    errors = 0;
    logic  rdy_at_edge = 1'b0;

    instruction_fetcher dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .isq_full          (isq_full),
        .roll_back         (roll_back),
        .rollback_pc       (rollback_pc),
        .icache_req        (icache_req),
        .icache_addr       (icache_addr),
        .icache_valid      (icache_valid),
        .icache_data       (icache_data),
        .instruction_ready (instruction_ready),
        .instruction_out   (instruction_out),
        .pc_out            (pc_out),
        .pred_taken_out    (pred_taken_out),
        .bht_update        (bht_update),
        .bht_update_pc     (bht_update_pc),
        .bht_update_taken  (bht_update_taken)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // A paused edge keeps the previous push visible; only count fresh pushes.
    always @(posedge clk_in) rdy_at_edge = rdy_in;

    always @(negedge clk_in) begin
        if (rst_in && rdy_at_edge && instruction_ready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_push", 32'(instruction_ready), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("push_instr", instruction_out, mon_e.instr);
                check_output("push_pc", pc_out, mon_e.pc);
                check_output("push_pred", 32'(pred_taken_out), 32'(mon_e.pred));
            end
        end
    end

    task automatic wait_req(input logic [31:0] addr, input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk_in);
            if (icache_req) seen = 1'b1;
        end
        if (seen) check_output(tag, icache_addr, addr);
        else check_output({tag, "_timeout"}, 32'(seen), 32'd1);
    endtask

    // Deliver one icache response; queue the expected push unless it should be dropped.
    task automatic apply_stimulus(input logic [31:0] data, input logic [31:0] pc,
                                  input logic pred, input bit expect_push);
        icache_valid = 1'b1;
        icache_data  = data;
        if (expect_push) begin
            new_e.instr = data;
            new_e.pc    = pc;
            new_e.pred  = pred;
            exp_q.push_back(new_e);
        end
        @(negedge clk_in);
        icache_valid = 1'b0;
        if (!expect_push) check_output("drop_no_ready", 32'(instruction_ready), 32'd0);
    endtask

    task automatic bht_train(input logic [31:0] pc, input logic taken);
        bht_update       = 1'b1;
        bht_update_pc    = pc;
        bht_update_taken = taken;
        @(negedge clk_in);
        bht_update = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_in           = 1'b0;
        rdy_in           = 1'b1;
        isq_full         = 1'b0;
        roll_back        = 1'b0;
        rollback_pc      = 32'h0;
        icache_valid     = 1'b0;
        icache_data      = 32'h0;
        bht_update       = 1'b0;
        bht_update_pc    = 32'h0;
        bht_update_taken = 1'b0;

        repeat (2) @(negedge clk_in);
        check_output("rst_req", 32'(icache_req), 32'd0);
        check_output("rst_addr", icache_addr, 32'h0);
        check_output("rst_ready", 32'(instruction_ready), 32'd0);
        check_output("rst_instr", instruction_out, 32'h0);
        check_output("rst_pc_out", pc_out, 32'h0);
        check_output("rst_pred", 32'(pred_taken_out), 32'd0);
        rst_in = 1'b1;

        @(negedge clk_in);
        check_output("first_req", 32'(icache_req), 32'd1);
        check_output("first_addr", icache_addr, 32'h0);
        apply_stimulus(NOP, 32'h0, 1'b0, 1'b1);
        wait_req(32'h4, "req_4");
        apply_stimulus(NOP, 32'h4, 1'b0, 1'b1);
        wait_req(32'h8, "req_8");
        apply_stimulus(NOP, 32'h8, 1'b0, 1'b1);
        wait_req(32'hC, "req_c");
        apply_stimulus(NOP, 32'hC, 1'b0, 1'b1);

        wait_req(32'h10, "req_10");
        apply_stimulus(JAL1, 32'h10, 1'b1, 1'b1);
        wait_req(32'h20, "jal_target_20");
        apply_stimulus(JAL2, 32'h20, 1'b1, 1'b1);
        wait_req(32'h40, "jal_target_40");
        apply_stimulus(BEQ, 32'h40, 1'b0, 1'b1);
        wait_req(32'h44, "beq_weak_nt");

        bht_train(32'h40, 1'b1);
        bht_train(32'h40, 1'b1);
        roll_back   = 1'b1;
        rollback_pc = 32'h40;
        @(negedge clk_in);
        roll_back = 1'b0;
        check_output("rb_wait_no_req", 32'(icache_req), 32'd0);
        repeat (2) @(negedge clk_in);
        apply_stimulus(NOP, 32'h44, 1'b0, 1'b0);
        wait_req(32'h40, "rb_refetch_40");
        apply_stimulus(BEQ, 32'h40, 1'b1, 1'b1);
        wait_req(32'h48, "beq_strong_t");

        repeat (4) bht_train(32'h40, 1'b0);
        bht_train(32'h40, 1'b1);
        icache_valid = 1'b1;
        icache_data  = NOP;
        roll_back    = 1'b1;
        rollback_pc  = 32'h40;
        @(negedge clk_in);
        icache_valid = 1'b0;
        roll_back    = 1'b0;
        check_output("rb_coincident_drop", 32'(instruction_ready), 32'd0);
        wait_req(32'h40, "rb_coincident_40");
        apply_stimulus(BEQ, 32'h40, 1'b0, 1'b1);

        isq_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check_output("isq_full_no_req", 32'(icache_req), 32'd0);
        end
        isq_full = 1'b0;
        @(negedge clk_in);
        check_output("isq_release_req", 32'(icache_req), 32'd1);
        check_output("isq_release_addr", icache_addr, 32'h44);

        apply_stimulus(ADDI, 32'h44, 1'b0, 1'b1);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check_output("pause_ready", 32'(instruction_ready), 32'd1);
            check_output("pause_instr", instruction_out, ADDI);
            check_output("pause_pc_out", pc_out, 32'h44);
            check_output("pause_no_req", 32'(icache_req), 32'd0);
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        check_output("resume_ready_clear", 32'(instruction_ready), 32'd0);
        check_output("resume_req", 32'(icache_req), 32'd1);
        check_output("resume_addr", icache_addr, 32'h48);

        roll_back   = 1'b1;
        rollback_pc = 32'h100;
        @(negedge clk_in);
        roll_back = 1'b0;
        repeat (2) @(negedge clk_in);
        check_output("discard_wait_no_req", 32'(icache_req), 32'd0);
        apply_stimulus(NOP, 32'h48, 1'b0, 1'b0);
        wait_req(32'h100, "rb_target_100");
        apply_stimulus(NOP, 32'h100, 1'b0, 1'b1);

        roll_back   = 1'b1;
        rollback_pc = 32'h200;
        @(negedge clk_in);
        roll_back = 1'b0;
        check_output("no_req_in_rb_cycle", 32'(icache_req), 32'd0);
        wait_req(32'h200, "rb_idle_target_200");

        repeat (3) @(negedge clk_in);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
